// File: rtl/ldpc_res_drain_if.sv
// ldpc_res_drain_if: decision-word stream (valid/ready, last-qualified) leaving the result drain.
interface ldpc_res_drain_if #(parameter int OUT_W = 16);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ldpc_res_drain.sv
// ldpc_res_drain: snapshots decoder hard decisions on termination, streams them MSB-first and counts bit errors.
// Build option LDPC_DRAIN_CUMUL_EN: errs becomes a saturating running total across frames.
module ldpc_res_drain #(
    parameter int R      = 24,
    parameter int D      = 96,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 12,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_valid,
    input  logic              i_term,
    input  logic [R*D-1:0]    i_res_in,
    output logic              o_release,
    ldpc_res_drain_if.master  bus,
    output logic [CNT_W-1:0]  o_errs,
    output logic              o_err_valid,
    output logic [FCNT_W-1:0] o_frames
);
    localparam int DIM   = R * D;
    localparam int WORDS = DIM / OUT_W;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIM-1:0]   r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_pop;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_errs_nxt;
    logic             w_cap;
    logic             w_hs;
    logic             w_last_word;
    logic             w_last_hs;

    assign bus.out_valid = (r_state == SEND);
    assign bus.out_data  = r_shadow[DIM-1 -: OUT_W];
    assign w_last_word   = (r_idx == IDX_W'(WORDS - 1));
    assign bus.out_last  = bus.out_valid & w_last_word;
    assign w_hs          = bus.out_valid & bus.out_ready;
    assign w_last_hs     = w_hs & w_last_word;
    assign w_cap         = (r_state == IDLE) & i_frame_valid & i_term;
    assign w_cnt         = r_acc + w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < OUT_W; i++) w_pop = w_pop + CNT_W'(r_shadow[DIM-OUT_W+i]);
    end

`ifdef LDPC_DRAIN_CUMUL_EN
    logic [CNT_W:0] w_sum;
    assign w_sum      = {1'b0, o_errs} + {1'b0, w_cnt};
    assign w_errs_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
`else
    assign w_errs_nxt = w_cnt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_cap ? SEND : (w_last_hs ? IDLE : r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Capture and handshake are exclusive: capture only happens in IDLE, handshakes only in SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            o_release   <= 1'b0;
            o_errs      <= '0;
            o_err_valid <= 1'b0;
            o_frames    <= '0;
        end else begin
            o_release   <= w_cap;
            o_err_valid <= w_last_hs;
            if (w_cap) begin
                r_shadow <= i_res_in;
                r_idx    <= '0;
                r_acc    <= '0;
            end else if (w_hs) begin
                r_shadow <= r_shadow << OUT_W;
                r_idx    <= r_idx + IDX_W'(1);
                r_acc    <= w_cnt;
            end
            if (w_last_hs) begin
                o_errs   <= w_errs_nxt;
                o_frames <= o_frames + FCNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ldpc_res_drain.sv
// tb_ldpc_res_drain: directed scoreboard bench for the result drain (both errs build modes).
module tb_ldpc_res_drain;
    localparam int R = 24, D = 96, OUT_W = 16, CNT_W = 12, FCNT_W = 16;
    localparam int DIM = R * D, WORDS = DIM / OUT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fv = 1'b0;
    logic              term = 1'b0;
    logic [DIM-1:0]    res = '0;
    logic              rel;
    logic [CNT_W-1:0]  errs;
    logic              err_valid;
    logic [FCNT_W-1:0] frames;

    int n_assert = 0, n_fail = 0;
    int n_rel = 0, n_ev = 0, n_words = 0;
    int model_errs = 0, model_frames = 0;
    logic [CNT_W-1:0] ev_errs = '0;
    logic [16:0]      exp_q[$];
    logic             prev_stall = 1'b0;
    logic [15:0]      prev_data = '0;
    logic             prev_last = 1'b0;

    ldpc_res_drain_if #(.OUT_W(OUT_W)) bus ();

    ldpc_res_drain #(.R(R), .D(D), .OUT_W(OUT_W), .CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .i_frame_valid(fv), .i_term(term), .i_res_in(res),
        .o_release(rel), .bus(bus), .o_errs(errs), .o_err_valid(err_valid), .o_frames(frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Monitor: pulse counters, hold-under-backpressure checks, scoreboard pops on handshakes.
    always @(negedge clk) begin
        if (rel === 1'b1) n_rel++;
        if (err_valid === 1'b1) begin
            n_ev++;
            ev_errs = errs;
        end
        if (prev_stall) begin
            chk("hold_data", bus.out_data, prev_data);
            chk("hold_last", bus.out_last, prev_last);
        end
        prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready && !rst;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        if ((bus.out_valid === 1'b1) && bus.out_ready && !rst) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_word: observed %0h expected no word", bus.out_data);
            end
            if (exp_q.size() > 0) chk("word", {bus.out_last, bus.out_data}, exp_q.pop_front());
            n_words++;
        end
    end

    task automatic push_frame(input logic [DIM-1:0] v);
        int cnt;
        for (int k = 0; k < WORDS; k++) exp_q.push_back({k == WORDS - 1, v[DIM-1-16*k -: 16]});
        cnt = $countones(v);
`ifdef LDPC_DRAIN_CUMUL_EN
        model_errs = (model_errs + cnt > 4095) ? 4095 : model_errs + cnt;
`else
        model_errs = cnt;
`endif
        model_frames++;
    endtask

    task automatic run_frame(input logic [DIM-1:0] v, input int stall_at, input bit hold);
        int ev0, rel0, w0, nf;
        bit stalled;
        ev0 = n_ev; rel0 = n_rel; w0 = n_words; nf = hold ? 2 : 1; stalled = 1'b0;
        push_frame(v);
        if (hold) push_frame(v);
        res = v; fv = 1'b1; term = 1'b1;
        step;
        if (!hold) begin fv = 1'b0; term = 1'b0; end
        for (int c = 0; c < 1000 && n_ev < ev0 + nf; c++) begin
            if (hold && n_ev == ev0 + 1) begin fv = 1'b0; term = 1'b0; end
            if (!stalled && stall_at >= 0 && n_words - w0 == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (5) step;
                bus.out_ready = 1'b1;
                stalled = 1'b1;
            end
            step;
        end
        fv = 1'b0; term = 1'b0;
        chk("frame_done", n_ev, ev0 + nf);
        step; step;
        chk("release_count", n_rel - rel0, nf);
        chk("word_count", n_words - w0, nf * WORDS);
        chk("queue_empty", exp_q.size(), 0);
        chk("errs_pulse", ev_errs, model_errs);
        chk("errs", errs, model_errs);
        chk("frames", frames, model_frames);
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_last", bus.out_last, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_release"}, rel, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_errs"}, errs, 0);
        chk({tag, "_err_valid"}, err_valid, 0);
        chk({tag, "_frames"}, frames, 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
        exp_q.delete();
        model_errs = 0;
        model_frames = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DIM-1:0] v;
        int rel0, w0;
        bus.out_ready = 1'b1;
        repeat (3) step;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        step;

        // 1: all-zero frame
        run_frame('0, -1, 1'b0);
        // 2: first and last bits set
        v = '0; v[DIM-1] = 1'b1; v[0] = 1'b1;
        run_frame(v, -1, 1'b0);
        chk("two_bit_errs", errs, 2);
        // 3: word k = k with a 5-cycle stall at word 10
        v = '0;
        for (int k = 0; k < WORDS; k++) v[DIM-1-16*k -: 16] = 16'(k);
        run_frame(v, 10, 1'b0);

        // 4a: term without frame_valid
        rel0 = n_rel;
        term = 1'b1;
        repeat (5) step;
        term = 1'b0;
        chk("no_cap_release", n_rel - rel0, 0);
        chk("no_cap_valid", bus.out_valid, 0);
        // 4b: capture request held through SEND -> exactly one recapture after IDLE
        v = '0; v[100] = 1'b1;
        run_frame(v, -1, 1'b1);

        // capture requested in the reset cycle is dropped
        rel0 = n_rel;
        rst = 1'b1; fv = 1'b1; term = 1'b1;
        step;
        rst = 1'b0; fv = 1'b0; term = 1'b0;
        exp_q.delete(); model_errs = 0; model_frames = 0;
        step; step;
        chk("rst_cap_release", n_rel - rel0, 0);
        chk("rst_cap_valid", bus.out_valid, 0);

        // 5: reset after 50 accepted words
        v = '1;
        w0 = n_words;
        push_frame(v);
        res = v; fv = 1'b1; term = 1'b1;
        step;
        fv = 1'b0; term = 1'b0;
        for (int c = 0; c < 400 && n_words - w0 < 50; c++) step;
        chk("mid_words", n_words - w0, 50);
        do_reset;
        @(negedge clk);
        check_zero("mid_rst");
        v = '0; v[7] = 1'b1; v[2000] = 1'b1; v[1234] = 1'b1; v[1235] = 1'b1;
        run_frame(v, -1, 1'b0);
        chk("post_rst_errs", errs, 4);

        // 6: 3 then 5 errors, then all-ones after reset
        do_reset;
        v = '0; v[5] = 1'b1; v[700] = 1'b1; v[DIM-1] = 1'b1;
        run_frame(v, -1, 1'b0);
        chk("errs_first", errs, 3);
        v = '0; v[0] = 1'b1; v[1] = 1'b1; v[17] = 1'b1; v[1000] = 1'b1; v[2200] = 1'b1;
        run_frame(v, -1, 1'b0);
`ifdef LDPC_DRAIN_CUMUL_EN
        chk("errs_second", errs, 8);
`else
        chk("errs_second", errs, 5);
`endif
        do_reset;
        run_frame('1, -1, 1'b0);
        chk("errs_all_ones", errs, 2304);
        run_frame('1, -1, 1'b0);
`ifdef LDPC_DRAIN_CUMUL_EN
        chk("errs_saturate", errs, 4095);
`else
        chk("errs_saturate", errs, 2304);
`endif
        chk("frames_final", frames, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
